// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, ALU select
// codes, Opcode/Funct constants and the bundled control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    RTEXE  = 4'd7,
    RTWB   = 4'd8,
    IEXE   = 4'd9,
    IWB    = 4'd10,
    BRANCH = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch_eq;
    logic       branch_neq;
    logic       pc_src;
    logic       alu_src_a;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/multi_cycle_control_alu_decoder.sv
// Combinational Funct/Opcode to ALU select decode for R-type and immediate ops.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  output logic [3:0] rt_alu,
  output logic [3:0] i_alu,
  output logic       funct_legal
);

  always_comb begin
    rt_alu      = ALU_ADD;
    funct_legal = 1'b1;
    case (Funct)
      FN_ADD:  rt_alu = ALU_ADD;
      FN_SUB:  rt_alu = ALU_SUB;
      FN_AND:  rt_alu = ALU_AND;
      FN_OR:   rt_alu = ALU_OR;
      FN_SLT:  rt_alu = ALU_SLT;
      FN_NOR:  rt_alu = ALU_NOR;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    i_alu = ALU_ADD;
    case (Opcode)
      OP_ANDI: i_alu = ALU_AND;
      OP_ORI:  i_alu = ALU_OR;
      OP_SLTI: i_alu = ALU_SLT;
      default: i_alu = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM with retired-instruction counter and sticky
// illegal-instruction flag.
module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             BranchEq,
  output logic             BranchNeq,
  output logic             PCSrc,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUControl,
  output logic             retire_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic             illegal_o,
  output logic [3:0]       state_o
);

  state_t           state, nxt;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] cnt;
  logic             illegal;
  logic             set_illegal;
  logic [3:0]       rt_alu, i_alu;
  logic             funct_legal;

  alu_decoder u_alu_decoder (
    .Opcode      (Opcode),
    .Funct       (Funct),
    .rt_alu      (rt_alu),
    .i_alu       (i_alu),
    .funct_legal (funct_legal)
  );

  // Outputs are registered from the next state, so they always reflect the
  // state register; Opcode/Funct are stable from the IR once DECODE begins.
  function automatic ctrl_t decode_ctrl(state_t s, logic [3:0] rt_sel,
                                        logic [3:0] i_sel, logic is_beq);
    ctrl_t c;
    c = '0;
    c.alu_control = ALU_ADD;
    case (s)
      IDLE:   c.alu_control = '0;
      FETCH:  begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = SRCB_FOUR; end
      DECODE: c.alu_src_b = SRCB_IMM_SH;
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
      MEMRD:  c.iord = 1'b1;
      MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.retire = 1'b1; end
      MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; c.retire = 1'b1; end
      RTEXE:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG; c.alu_control = rt_sel; end
      RTWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.retire = 1'b1; end
      IEXE:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_control = i_sel; end
      IWB:    begin c.reg_write = 1'b1; c.retire = 1'b1; end
      BRANCH: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_REG;
        c.alu_control = ALU_SUB;
        c.pc_src      = 1'b1;
        c.branch_eq   = is_beq;
        c.branch_neq  = ~is_beq;
        c.retire      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_t done_st;
    done_st     = halt ? IDLE : FETCH;
    nxt         = state;
    set_illegal = 1'b0;
    unique case (state)
      IDLE:   nxt = halt ? IDLE : FETCH;
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:                     nxt = MEMADR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = IEXE;
          OP_BEQ, OP_BNE:                   nxt = BRANCH;
          OP_RTYPE: begin
            if (funct_legal) begin
              nxt = RTEXE;
            end else begin
              nxt         = done_st;
              set_illegal = 1'b1;
            end
          end
          default: begin
            nxt         = done_st;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: nxt = (Opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  nxt = MEMWB;
      RTEXE:  nxt = RTWB;
      IEXE:   nxt = IWB;
      MEMWB, MEMWR, RTWB, IWB, BRANCH: nxt = done_st;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ctrl    <= '0;
      cnt     <= '0;
      illegal <= 1'b0;
    end else begin
      state <= nxt;
      ctrl  <= decode_ctrl(nxt, rt_alu, i_alu, Opcode == OP_BEQ);
      if (ctrl.retire) cnt <= cnt + CNT_W'(1);
      if (set_illegal) illegal <= 1'b1;
    end
  end

  assign IorD        = ctrl.iord;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign PCWrite     = ctrl.pc_write;
  assign BranchEq    = ctrl.branch_eq;
  assign BranchNeq   = ctrl.branch_neq;
  assign PCSrc       = ctrl.pc_src;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUControl  = ctrl.alu_control;
  assign retire_o    = ctrl.retire;
  assign instr_cnt_o = cnt;
  assign illegal_o   = illegal;
  assign state_o     = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_multi_cycle_control;

  localparam int CW = 4;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                         ST_MEMADR = 4'd3, ST_MEMRD = 4'd4, ST_MEMWB = 4'd5,
                         ST_MEMWR = 4'd6, ST_RTEXE = 4'd7, ST_RTWB = 4'd8,
                         ST_IEXE = 4'd9, ST_IWB = 4'd10, ST_BRANCH = 4'd11;

  logic          clk = 1'b0;
  logic          reset;
  logic          halt;
  logic [5:0]    Opcode, Funct;
  logic          IorD, MemWrite, IRWrite, PCWrite, BranchEq, BranchNeq, PCSrc;
  logic          ALUSrcA, RegWrite, MemtoReg, RegDst, retire_o, illegal_o;
  logic [1:0]    ALUSrcB;
  logic [3:0]    ALUControl, state_o;
  logic [CW-1:0] instr_cnt_o;
  logic [17:0]   obs;

  int            checks = 0;
  int            passes = 0;
  logic [CW-1:0] model_cnt;
  logic          model_ill;

  multi_cycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .halt(halt), .Opcode(Opcode), .Funct(Funct),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .BranchEq(BranchEq), .BranchNeq(BranchNeq), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .retire_o(retire_o), .instr_cnt_o(instr_cnt_o), .illegal_o(illegal_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign obs = {IorD, MemWrite, IRWrite, PCWrite, BranchEq, BranchNeq, PCSrc,
                ALUSrcA, RegWrite, MemtoReg, RegDst, ALUSrcB, ALUControl, retire_o};

  function automatic logic [3:0] ref_rt(logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b100111: return 4'b1100;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [3:0] ref_i(logic [5:0] op);
    case (op)
      6'b001100: return 4'b0000;
      6'b001101: return 4'b0001;
      6'b001010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // 0 lw, 1 sw, 2 R-type, 3 I-type, 4 branch, 5 illegal
  function automatic int classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b100011: return 0;
      6'b101011: return 1;
      6'b000000: return (ref_rt(fn) == 4'b1111) ? 5 : 2;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return 3;
      6'b000100, 6'b000101: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic logic [17:0] exp_ctrl(logic [3:0] st, logic [5:0] op, logic [5:0] fn);
    logic iord, mw, irw, pcw, beq, bne, pcs, asa, rw, m2r, rd, ret;
    logic [1:0] asb;
    logic [3:0] alu;
    {iord, mw, irw, pcw, beq, bne, pcs, asa, rw, m2r, rd, ret} = '0;
    asb = 2'b00;
    alu = (st == ST_IDLE) ? 4'b0000 : 4'b0010;
    case (st)
      ST_FETCH:  begin irw = 1; pcw = 1; asb = 2'b01; end
      ST_DECODE: asb = 2'b11;
      ST_MEMADR: begin asa = 1; asb = 2'b10; end
      ST_MEMRD:  iord = 1;
      ST_MEMWB:  begin rw = 1; m2r = 1; ret = 1; end
      ST_MEMWR:  begin iord = 1; mw = 1; ret = 1; end
      ST_RTEXE:  begin asa = 1; alu = ref_rt(fn); end
      ST_RTWB:   begin rw = 1; rd = 1; ret = 1; end
      ST_IEXE:   begin asa = 1; asb = 2'b10; alu = ref_i(op); end
      ST_IWB:    begin rw = 1; ret = 1; end
      ST_BRANCH: begin
        asa = 1; alu = 4'b0110; pcs = 1; ret = 1;
        beq = (op == 6'b000100); bne = (op == 6'b000101);
      end
      default: ;
    endcase
    return {iord, mw, irw, pcw, beq, bne, pcs, asa, rw, m2r, rd, asb, alu, ret};
  endfunction

  // Precondition: FETCH has just been observed. mode 0: halt low; 1: random
  // halt each cycle; 2: halt raised from the third state onward.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int mode, input string tag);
    logic [3:0] seq[$];
    logic       last_halt;
    int         c, n;
    c = classify(op, fn);
    case (c)
      0: seq = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB};
      1: seq = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWR};
      2: seq = '{ST_FETCH, ST_DECODE, ST_RTEXE, ST_RTWB};
      3: seq = '{ST_FETCH, ST_DECODE, ST_IEXE, ST_IWB};
      4: seq = '{ST_FETCH, ST_DECODE, ST_BRANCH};
      default: seq = '{ST_FETCH, ST_DECODE};
    endcase
    Opcode = op;
    Funct  = fn;
    last_halt = 1'b0;
    for (int k = 0; k < seq.size(); k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      checks++;
      if ({state_o, obs} !== {seq[k], exp_ctrl(seq[k], op, fn)})
        $display("FAIL %s step%0d: state/ctrl got %h_%h expected %h_%h", tag, k,
                 state_o, obs, seq[k], exp_ctrl(seq[k], op, fn));
      else passes++;
      case (mode)
        1:       halt = ($urandom_range(0, 3) == 0);
        2:       halt = (k >= 2);
        default: halt = 1'b0;
      endcase
      last_halt = halt;
    end
    if (c == 5) model_ill = 1'b1;
    else        model_cnt = model_cnt + 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({state_o, instr_cnt_o, illegal_o} !== {(last_halt ? ST_IDLE : ST_FETCH), model_cnt, model_ill})
      $display("FAIL %s end: state/cnt/ill got %0d/%0d/%0b expected %0d/%0d/%0b", tag,
               state_o, instr_cnt_o, illegal_o, last_halt ? ST_IDLE : ST_FETCH, model_cnt, model_ill);
    else passes++;
    if (last_halt) begin
      n = (mode == 1) ? int'($urandom_range(0, 2)) : 0;
      for (int w = 0; w < n; w++) begin
        @(posedge clk); #1;
        checks++;
        if ({state_o, obs} !== {ST_IDLE, 18'd0})
          $display("FAIL %s idle_hold: state/ctrl got %h_%h expected %h_%h", tag, state_o, obs, ST_IDLE, 18'd0);
        else passes++;
      end
      halt = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (state_o !== ST_FETCH)
        $display("FAIL %s resume: state got %0d expected %0d", tag, state_o, ST_FETCH);
      else passes++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; halt = 1'b1; Opcode = '0; Funct = '0;
    model_cnt = '0; model_ill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({state_o, obs, instr_cnt_o, illegal_o} !== {ST_IDLE, 18'd0, {CW{1'b0}}, 1'b0})
      $display("FAIL reset: state/ctrl/cnt/ill got %h_%h_%h_%b expected all zero", state_o, obs, instr_cnt_o, illegal_o);
    else passes++;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state_o !== ST_IDLE) $display("FAIL reset_halt_hold: state got %0d expected %0d", state_o, ST_IDLE);
    else passes++;
    halt = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state_o !== ST_FETCH) $display("FAIL reset_first_fetch: state got %0d expected %0d", state_o, ST_FETCH);
    else passes++;
  endtask

  task automatic test_lw;
    run_instr(6'b100011, 6'($urandom), 0, "lw");
  endtask

  task automatic test_rtype_sub;
    run_instr(6'b000000, 6'b100010, 0, "rtype_sub");
  endtask

  task automatic test_bne;
    run_instr(6'b000101, 6'($urandom), 0, "bne");
  endtask

  task automatic test_illegal;
    run_instr(6'b111111, 6'($urandom), 0, "illegal_op");
    run_instr(6'b000000, 6'b111111, 0, "illegal_funct");
  endtask

  task automatic test_halt_rtexe;
    run_instr(6'b000000, 6'b100000, 2, "halt_rtexe");
  endtask

  task automatic test_random;
    logic [5:0] ops[9];
    logic [5:0] fns[6];
    logic [5:0] op, fn;
    int         sel;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100,
            6'b001101, 6'b001010, 6'b000100, 6'b000101};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 10));
      fn  = fns[$urandom_range(0, 5)];
      if (sel < 9)       op = ops[sel];
      else if (sel == 9) op = 6'($urandom);
      else begin op = 6'b000000; fn = 6'($urandom); end
      run_instr(op, fn, 1, "random");
    end
  endtask

  task automatic test_wrap;
    int guard;
    guard = 0;
    while (model_cnt != {CW{1'b1}} && guard < 20) begin
      run_instr(6'b001000, 6'($urandom), 0, "wrap_fill");
      guard++;
    end
    checks++;
    if (instr_cnt_o !== {CW{1'b1}}) $display("FAIL wrap_preload: cnt got %0d expected %0d", instr_cnt_o, {CW{1'b1}});
    else passes++;
    run_instr(6'b101011, 6'($urandom), 0, "wrap_sw");
    checks++;
    if (instr_cnt_o !== {CW{1'b0}}) $display("FAIL wrap_zero: cnt got %0d expected 0", instr_cnt_o);
    else passes++;
  endtask

  task automatic test_reset_mid;
    Opcode = 6'b100011; Funct = '0; halt = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (state_o !== ST_MEMRD) $display("FAIL reset_mid_pre: state got %0d expected %0d", state_o, ST_MEMRD);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state_o, obs, instr_cnt_o, illegal_o} !== {ST_IDLE, 18'd0, {CW{1'b0}}, 1'b0})
      $display("FAIL reset_mid: state/ctrl/cnt/ill got %h_%h_%h_%b expected all zero", state_o, obs, instr_cnt_o, illegal_o);
    else passes++;
    model_cnt = '0; model_ill = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({state_o, obs} !== {ST_IDLE, 18'd0})
      $display("FAIL reset_mid_hold: state/ctrl got %h_%h expected %h_%h", state_o, obs, ST_IDLE, 18'd0);
    else passes++;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state_o !== ST_FETCH) $display("FAIL reset_mid_fetch: state got %0d expected %0d", state_o, ST_FETCH);
    else passes++;
    run_instr(6'b000100, 6'($urandom), 0, "post_reset_beq");
  endtask

  initial begin
    test_reset;
    test_lw;
    test_rtype_sub;
    test_bne;
    test_illegal;
    test_halt_rtexe;
    test_random;
    test_wrap;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
